// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one single-port synchronous data memory between the
// two issue lanes. Lane p0 is the older instruction and p1 the younger one.
// Conflicting same-cycle accesses are serialised in program order, costing one
// stall cycle. Redundant accesses (same-address load/load or store/store) are
// merged into a single DM access.
module dm_port_arbiter #(
  parameter int AW    = 9,
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // lane p0 (older)
  input  logic             p0_req,
  input  logic             p0_DM_write_mem,
  input  logic [AW-1:0]    p0_DM_maddr,
  input  logic [DW-1:0]    p0_DM_wdata,
  output logic [DW-1:0]    p0_DM_rdata,
  output logic             p0_rvalid,
  // lane p1 (younger)
  input  logic             p1_req,
  input  logic             p1_DM_write_mem,
  input  logic [AW-1:0]    p1_DM_maddr,
  input  logic [DW-1:0]    p1_DM_wdata,
  output logic [DW-1:0]    p1_DM_rdata,
  output logic             p1_rvalid,
  // pipeline control
  output logic             stall,
  // data memory macro
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  // statistics
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {
    IDLE,
    SERVE_P1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state_q, state_d;

  // p1 access deferred by a conflict, replayed in SERVE_P1
  logic            cap_we_q;
  logic [AW-1:0]   cap_addr_q;
  logic [DW-1:0]   cap_wdata_q;
  logic            capture;

  // a load is granted for the lane this cycle; its data returns next cycle
  logic            rd_p0, rd_p1;

  // last returned read data per lane, held between loads
  logic [DW-1:0]   p0_hold_q, p1_hold_q;

  logic            same_addr;
  assign same_addr = (p0_DM_maddr == p1_DM_maddr);

  // Arbitration: next state, DM drive, stall and capture request.
  // Outputs are forced to their idle values while reset is asserted so that
  // the DM sees no access and the pipeline is released at once.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_d   = state_q;
    stall     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    capture   = 1'b0;
    rd_p0     = 1'b0;
    rd_p1     = 1'b0;

    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (p0_req && p1_req) begin
            if (!p0_DM_write_mem && !p1_DM_write_mem && same_addr) begin
              // merged load: one read feeds both lanes
              mem_en   = 1'b1;
              mem_addr = p0_DM_maddr;
              rd_p0    = 1'b1;
              rd_p1    = 1'b1;
            end else if (p0_DM_write_mem && p1_DM_write_mem && same_addr) begin
              // merged store: the younger write wins, p0 data is dropped
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = p1_DM_maddr;
              mem_wdata = p1_DM_wdata;
            end else begin
              // conflict: p0 first, p1 replayed next cycle
              mem_en    = 1'b1;
              mem_we    = p0_DM_write_mem;
              mem_addr  = p0_DM_maddr;
              mem_wdata = p0_DM_wdata;
              rd_p0     = !p0_DM_write_mem;
              stall     = 1'b1;
              capture   = 1'b1;
              state_d   = SERVE_P1;
            end
          end else if (p0_req) begin
            mem_en    = 1'b1;
            mem_we    = p0_DM_write_mem;
            mem_addr  = p0_DM_maddr;
            mem_wdata = p0_DM_wdata;
            rd_p0     = !p0_DM_write_mem;
          end else if (p1_req) begin
            mem_en    = 1'b1;
            mem_we    = p1_DM_write_mem;
            mem_addr  = p1_DM_maddr;
            mem_wdata = p1_DM_wdata;
            rd_p1     = !p1_DM_write_mem;
          end
        end

        SERVE_P1: begin
          // lane inputs are ignored; replay the captured p1 access
          mem_en    = 1'b1;
          mem_we    = cap_we_q;
          mem_addr  = cap_addr_q;
          mem_wdata = cap_wdata_q;
          rd_p1     = !cap_we_q;
          state_d   = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture the deferred p1 access on a conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the capture register is reset as well, so a request caught before
    // reset can never be replayed after it.
    if (!rst_n) begin
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else if (capture) begin
      cap_we_q    <= p1_DM_write_mem;
      cap_addr_q  <= p1_DM_maddr;
      cap_wdata_q <= p1_DM_wdata;
    end
  end

  // Read-return pulses: a load granted in cycle N returns in N+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      p0_rvalid <= rd_p0;
      p1_rvalid <= rd_p1;
    end
  end

  // Hold the returned data until that lane's next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_hold_q <= '0;
      p1_hold_q <= '0;
    end else begin
      if (p0_rvalid) p0_hold_q <= mem_rdata;
      if (p1_rvalid) p1_hold_q <= mem_rdata;
    end
  end

  // The DM output register supplies the data in the return cycle; afterwards
  // the held copy keeps it stable.
  assign p0_DM_rdata = p0_rvalid ? mem_rdata : p0_hold_q;
  assign p1_DM_rdata = p1_rvalid ? mem_rdata : p1_hold_q;

  // Saturating count of inserted stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          conflict_cnt <= '0;
    else if (capture && conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a synchronous single-port memory
// model. CNT_W is 2 so counter saturation is reachable in a few conflicts.
module tb_dm_port_arbiter;

  localparam int AW    = 9;
  localparam int DW    = 16;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             p0_req, p0_DM_write_mem;
  logic [AW-1:0]    p0_DM_maddr;
  logic [DW-1:0]    p0_DM_wdata, p0_DM_rdata;
  logic             p0_rvalid;
  logic             p1_req, p1_DM_write_mem;
  logic [AW-1:0]    p1_DM_maddr;
  logic [DW-1:0]    p1_DM_wdata, p1_DM_rdata;
  logic             p1_rvalid;
  logic             stall, mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
  logic [CNT_W-1:0] conflict_cnt;

  int n_vec = 0;
  int n_err = 0;

  dm_port_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_DM_write_mem(p0_DM_write_mem), .p0_DM_maddr(p0_DM_maddr),
    .p0_DM_wdata(p0_DM_wdata), .p0_DM_rdata(p0_DM_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_DM_write_mem(p1_DM_write_mem), .p1_DM_maddr(p1_DM_maddr),
    .p1_DM_wdata(p1_DM_wdata), .p1_DM_rdata(p1_DM_rdata), .p1_rvalid(p1_rvalid),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Memory macro model plus access counters.
  logic [DW-1:0] mem [512];
  logic          preload;
  int            wr_cnt = 0;
  int            rd_cnt = 0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
      mem[9'h030] <= 16'h5A5A;
      mem[9'h040] <= 16'h0001;
      mem_rdata   <= '0;
    end else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_p0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_req = req; p0_DM_write_mem = we; p0_DM_maddr = a; p0_DM_wdata = d;
  endtask

  task automatic drive_p1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1_req = req; p1_DM_write_mem = we; p1_DM_maddr = a; p1_DM_wdata = d;
  endtask

  task automatic idle_lanes();
    drive_p0(1'b0, 1'b0, '0, '0);
    drive_p1(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int wr0, rd0;

  initial begin
    rst_n   = 1'b0;
    preload = 1'b1;
    idle_lanes();
    repeat (3) tick();

    // reset values
    check("rst_stall",  stall, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_rdata",  {p0_DM_rdata, p1_DM_rdata}, 0);
    check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    check("rst_cnt",    conflict_cnt, 0);
    rst_n   = 1'b1;
    preload = 1'b0;
    tick();

    // 1: p0 store, then p1 load of the same word
    wr0 = wr_cnt;
    drive_p0(1'b1, 1'b1, 9'h005, 16'h1234);
    #1;
    check("t1_drive", {mem_en, mem_we, 7'(mem_addr), mem_wdata}, {1'b1, 1'b1, 7'h05, 16'h1234});
    check("t1_stall0", stall, 0);
    tick();
    drive_p0(1'b0, 1'b0, '0, '0);
    drive_p1(1'b1, 1'b0, 9'h005, '0);
    #1;
    check("t1_load_drive", {mem_en, mem_we, stall}, 3'b100);
    tick();
    idle_lanes();
    check("t1_rvalid", {p0_rvalid, p1_rvalid}, 2'b01);
    check("t1_rdata", p1_DM_rdata, 16'h1234);
    check("t1_writes", wr_cnt - wr0, 1);
    tick();
    check("t1_rvalid_pulse", p1_rvalid, 0);
    check("t1_hold", p1_DM_rdata, 16'h1234);

    // 2: p0 store + p1 load same address -> one stall, program order
    drive_p0(1'b1, 1'b1, 9'h010, 16'hAAAA);
    drive_p1(1'b1, 1'b0, 9'h010, '0);
    #1;
    check("t2_n_stall", stall, 1);
    check("t2_n_p0_write", {mem_en, mem_we, 7'(mem_addr), mem_wdata}, {1'b1, 1'b1, 7'h10, 16'hAAAA});
    tick();
    check("t2_n1_stall", stall, 0);
    check("t2_n1_p1_read", {mem_en, mem_we, 7'(mem_addr)}, {1'b1, 1'b0, 7'h10});
    check("t2_n1_p0_rvalid", p0_rvalid, 0);
    tick();
    idle_lanes();
    check("t2_n2_rvalid", p1_rvalid, 1);
    check("t2_n2_rdata", p1_DM_rdata, 16'hAAAA);
    check("t2_cnt", conflict_cnt, 1);

    // 3: both stores same address -> single write of p1 data
    wr0 = wr_cnt;
    drive_p0(1'b1, 1'b1, 9'h020, 16'h1111);
    drive_p1(1'b1, 1'b1, 9'h020, 16'h2222);
    #1;
    check("t3_stall", stall, 0);
    check("t3_drive", {mem_we, 7'(mem_addr), mem_wdata}, {1'b1, 7'h20, 16'h2222});
    tick();
    idle_lanes();
    check("t3_one_write", wr_cnt - wr0, 1);
    drive_p0(1'b1, 1'b0, 9'h020, '0);
    tick();
    idle_lanes();
    check("t3_readback", {p0_rvalid, p0_DM_rdata}, {1'b1, 16'h2222});

    // 4: both loads same address -> one read, both lanes served
    rd0 = rd_cnt;
    drive_p0(1'b1, 1'b0, 9'h030, '0);
    drive_p1(1'b1, 1'b0, 9'h030, '0);
    #1;
    check("t4_stall", stall, 0);
    tick();
    idle_lanes();
    check("t4_one_read", rd_cnt - rd0, 1);
    check("t4_rvalid", {p0_rvalid, p1_rvalid}, 2'b11);
    check("t4_rdata", {p0_DM_rdata, p1_DM_rdata}, {16'h5A5A, 16'h5A5A});

    // 5: p0 load + p1 store same address -> p0 sees old data
    drive_p0(1'b1, 1'b0, 9'h040, '0);
    drive_p1(1'b1, 1'b1, 9'h040, 16'h0002);
    #1;
    check("t5_stall", stall, 1);
    tick();
    check("t5_p0_old", {p0_rvalid, p0_DM_rdata}, {1'b1, 16'h0001});
    check("t5_p1_write", {mem_we, mem_wdata, stall}, {1'b1, 16'h0002, 1'b0});
    tick();
    idle_lanes();
    check("t5_no_p1_rvalid", p1_rvalid, 0);
    check("t5_cnt", conflict_cnt, 2);
    drive_p1(1'b1, 1'b0, 9'h040, '0);
    tick();
    idle_lanes();
    check("t5_readback", p1_DM_rdata, 16'h0002);

    // 6a: reset during SERVE_P1 drops the captured p1 store
    drive_p0(1'b1, 1'b1, 9'h050, 16'h7777);
    drive_p1(1'b1, 1'b1, 9'h051, 16'h8888);
    tick();
    check("t6_serve_active", {mem_en, mem_we, 7'(mem_addr)}, {1'b1, 1'b1, 7'h51});
    check("t6_cnt_pre", conflict_cnt, 3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    check("t6_rst_misc", {stall, p0_rvalid, p1_rvalid, p0_DM_rdata, p1_DM_rdata, conflict_cnt}, 0);
    idle_lanes();
    tick();
    rst_n = 1'b1;
    tick();
    drive_p1(1'b1, 1'b0, 9'h051, '0);
    tick();
    idle_lanes();
    check("t6_p1_store_lost", {p1_rvalid, p1_DM_rdata}, {1'b1, 16'h0000});
    drive_p0(1'b1, 1'b0, 9'h050, '0);
    tick();
    idle_lanes();
    check("t6_p0_store_kept", p0_DM_rdata, 16'h7777);

    // 6b: five conflicts saturate the 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      drive_p0(1'b1, 1'b0, 9'h060, '0);
      drive_p1(1'b1, 1'b0, 9'h061, '0);
      tick();
      tick();
      idle_lanes();
      if (i == 2) check("t6_cnt_3", conflict_cnt, 3);
    end
    check("t6_cnt_sat", conflict_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
